// File: rtl/spi_slave_byte_stream_if.sv
// Byte stream handshake between the SPI slave front end and the packet bridge.
// The slave modport is the SPI block side; master is the bridge side.
interface spi_slave_byte_stream_if;
  logic [7:0] oRX_DATA;
  logic       oRX_VALID;
  logic       iRX_READY;
  logic [7:0] iTX_DATA;
  logic       iTX_VALID;
  logic       oTX_READY;

  modport slave (
    output oRX_DATA,
    output oRX_VALID,
    input  iRX_READY,
    input  iTX_DATA,
    input  iTX_VALID,
    output oTX_READY
  );

  modport master (
    input  oRX_DATA,
    input  oRX_VALID,
    output iRX_READY,
    output iTX_DATA,
    output iTX_VALID,
    input  oTX_READY
  );
endinterface

// File: rtl/spi_slave_byte_stream.sv
// SPI mode-0 slave, MSB first, oversampled in the iCLK domain.
// Received bytes leave as a valid/ready stream; transmit bytes enter through a 1-deep holding register.
module spi_slave_byte_stream #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'h4A
) (
  input  logic iCLK,
  input  logic iRESETn,
  input  logic iSCLK,
  input  logic iMOSI,
  input  logic iNSS,
  output logic oMISO,
  output logic oMISO_OE,
  output logic oOVERRUN,
  input  logic iOVR_CLR,
  spi_slave_byte_stream_if.slave stream
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned LAST   = SYNC_STAGES - 1;

  typedef enum logic {IDLE, ACTIVE} stateT;

  logic [SYNC_STAGES-1:0] sclkSync;
  logic [SYNC_STAGES-1:0] mosiSync;
  logic [SYNC_STAGES-1:0] nssSync;
  logic                   sclkDly;
  logic                   nssDly;
  logic                   sclkRise;
  logic                   sclkFall;
  logic                   nssFall;
  logic                   nssRise;

  stateT                  state;
  logic [CNT_W-1:0]       bitCnt;
  logic [BYTE_W-2:0]      rxShift;
  logic [BYTE_W-1:0]      txShift;
  logic                   misoOe;

  logic [BYTE_W-1:0]      rxData;
  logic                   rxValid;
  logic                   overrun;
  logic [BYTE_W-1:0]      txHold;
  logic                   txReady;

  logic                   mosiBit;
  logic [BYTE_W-1:0]      rxByte;
  logic                   byteDone;
  logic                   txLoad;
  logic [BYTE_W-1:0]      txNext;

  // Synchronizers and registered one-cycle edge strobes
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      sclkSync <= '0;
      mosiSync <= '0;
      nssSync  <= '1;
      sclkDly  <= 1'b0;
      nssDly   <= 1'b1;
      sclkRise <= 1'b0;
      sclkFall <= 1'b0;
      nssFall  <= 1'b0;
      nssRise  <= 1'b0;
    end else begin
      sclkSync <= {sclkSync[SYNC_STAGES-2:0], iSCLK};
      mosiSync <= {mosiSync[SYNC_STAGES-2:0], iMOSI};
      nssSync  <= {nssSync[SYNC_STAGES-2:0], iNSS};
      sclkDly  <= sclkSync[LAST];
      nssDly   <= nssSync[LAST];
      sclkRise <= sclkSync[LAST] & ~sclkDly;
      sclkFall <= ~sclkSync[LAST] & sclkDly;
      nssFall  <= ~nssSync[LAST] & nssDly;
      nssRise  <= nssSync[LAST] & ~nssDly;
    end
  end

  always_comb begin
    mosiBit  = mosiSync[LAST];
    rxByte   = {rxShift, mosiBit};
    byteDone = (state == ACTIVE) && !nssRise && sclkRise && (bitCnt == CNT_W'(7));
    txLoad   = ((state == IDLE) && nssFall) ||
               ((state == ACTIVE) && !nssRise && sclkFall && (bitCnt == CNT_W'(0)));
    txNext   = txReady ? IDLE_BYTE : txHold;
  end

  // Transfer FSM with RX/TX shift registers; oMISO is the top bit of txShift
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state   <= IDLE;
      bitCnt  <= '0;
      rxShift <= '0;
      txShift <= '0;
      misoOe  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (nssFall) begin
            state   <= ACTIVE;
            txShift <= txNext;
            misoOe  <= 1'b1;
            bitCnt  <= '0;
          end
        end
        ACTIVE: begin
          if (nssRise) begin
            state   <= IDLE;
            bitCnt  <= '0;
            rxShift <= '0;
            txShift <= '0;
            misoOe  <= 1'b0;
          end else begin
            if (sclkRise) begin
              rxShift <= rxByte[BYTE_W-2:0];
              bitCnt  <= bitCnt + CNT_W'(1);
            end
            if (sclkFall) begin
              if (bitCnt != CNT_W'(0)) begin
                txShift <= {txShift[BYTE_W-2:0], 1'b0};
              end else begin
                txShift <= txNext;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RX output register: accept on empty or same-cycle consume, otherwise flag overrun
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      rxData  <= '0;
      rxValid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (byteDone) begin
        if (!rxValid || stream.iRX_READY) begin
          rxData  <= rxByte;
          rxValid <= 1'b1;
        end
      end else if (rxValid && stream.iRX_READY) begin
        rxValid <= 1'b0;
      end
      if (iOVR_CLR) begin
        overrun <= 1'b0;
      end
      if (byteDone && rxValid && !stream.iRX_READY) begin
        overrun <= 1'b1;
      end
    end
  end

  // TX holding register; a load only empties it when full, a write only fills it when empty
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      txHold  <= '0;
      txReady <= 1'b1;
    end else begin
      if (txLoad && !txReady) begin
        txReady <= 1'b1;
      end
      if (stream.iTX_VALID && txReady) begin
        txHold  <= stream.iTX_DATA;
        txReady <= 1'b0;
      end
    end
  end

  assign oMISO            = txShift[BYTE_W-1];
  assign oMISO_OE         = misoOe;
  assign oOVERRUN         = overrun;
  assign stream.oRX_DATA  = rxData;
  assign stream.oRX_VALID = rxValid;
  assign stream.oTX_READY = txReady;

endmodule
